instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the pipelined RV32I core: owns the PC and issues word fetches to instruction memory.
//  Memory latency is variable; at most one fetch is outstanding.
//  Produces the IF/ID pipeline register (IR, PC, valid) consumed by the decode stage.
//  Honours decode stall, with a 1-entry hold buffer, and EX redirect/flush for taken branches and jumps.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of the first fetch after reset
//  NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0) loaded on flush/empty
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  stall        in   1   decode hazard; IF/ID register must hold
//  redirect     in   1   EX taken branch/jump; flush IF/ID, refetch
//  redirect_pc  in   32  target PC; bits [1:0] forced to 0 internally
//  imem_req     out  1   fetch request, accepted by memory in the same cycle
//  imem_addr    out  32  fetch word address (byte address, [1:0]=0)
//  imem_rvalid  in   1   read data valid, >=1 cycle after request
//  imem_rdata   in   32  instruction word
//  IF_ID_IR     out  32  registered instruction to decode
//  IF_ID_PC     out  32  registered PC of IF_ID_IR
//  IF_ID_valid  out  1   IF_ID_IR is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async): pc_r=RESET_PC, state=S_REQ, hold buffer empty, IF_ID_IR=NOP_INSTR, IF_ID_PC=0, IF_ID_valid=0.
//  imem_req is 0 while rst=1. The first request is issued in the first cycle after rst deasserts.
//  The FSM has four states: S_REQ, S_WAIT, S_DROP, S_HELD. Redirect has top priority in every state.
//   S_REQ : imem_req=1 and imem_addr=pc_r, then go to S_WAIT.
//           If redirect: imem_req=0, pc_r<=redirect_pc, stay in S_REQ.
//   S_WAIT: a response with !stall & !redirect loads IF/ID with {imem_rdata, pc_r, valid=1} and sets pc_r<=pc_r+4.
//           The same cycle also issues imem_req=1 with imem_addr=pc_r+4 and stays in S_WAIT (1 instr/cycle at 1-cycle memory).
//           A response with stall goes into the hold buffer {rdata, pc_r}, sets pc_r<=pc_r+4, goes to S_HELD, no request.
//           Redirect without a response: pc_r<=redirect_pc, go to S_DROP.
//           Redirect with a response: discard the data, pc_r<=redirect_pc, go to S_REQ.
//   S_DROP: imem_req=0. On imem_rvalid, discard the data and go to S_REQ.
//           Redirect in S_DROP updates pc_r and stays in S_DROP.
//   S_HELD: imem_req=0. When stall=0, move the hold buffer into IF/ID (valid=1), clear the buffer, go to S_REQ.
//           Redirect clears the buffer, sets pc_r<=redirect_pc, goes to S_REQ.
//  IF/ID register update, in priority order:
//   1. redirect: IR=NOP_INSTR, PC=0, valid=0.
//   2. stall: hold all fields.
//   3. new instruction: load it.
//   4. otherwise: bubble (IR=NOP_INSTR, valid=0, PC held).
//  Boundary rules:
//   - imem_rvalid in S_REQ or S_HELD is ignored; this includes stale responses after reset.
//   - pc_r+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//   - stall and redirect in the same cycle: redirect wins.
//   - rst asserted mid-fetch: all state is cleared immediately; a pending response is not awaited.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds two outputs.
//   if_fetch_cnt [31:0]: +1 per instruction written to IF/ID with valid=1.
//   if_bubble_cnt [31:0]: +1 per cycle IF/ID loads a bubble while stall=0.
//   Both reset to 0, wrap at 2^32, and their ports are present only when the macro is defined.
//  Not defined: no counters and no extra ports; all other behaviour is identical.
// TESTING
//  1. Reset release, 1-cycle memory returning addr-based data:
//     -> imem_addr 0,4,8,... on consecutive cycles; IF_ID_PC 0,4,8 with valid=1 every cycle from cycle 2.
//  2. Memory latency 3:
//     -> one outstanding request only; IF_ID_valid=1 once per 3 cycles; bubbles carry NOP 32'h00000013.
//  3. stall held 4 cycles while a response arrives:
//     -> IF/ID unchanged; hold buffer captures it; no imem_req.
//     -> on release, the held instruction appears next cycle and fetch resumes at held PC+4.
//  4. redirect to 32'h0000_0100 while a fetch is outstanding (latency 2):
//     -> IF_ID_valid=0 next cycle; the late response is dropped; next imem_addr=32'h100.
//  5. redirect and stall asserted together -> flush wins: IF_ID_valid=0, IR=NOP_INSTR.
//     redirect_pc=32'h103 -> fetch at 32'h100.
//  6. RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
//     rst pulsed mid-wait -> outputs at reset values at once; stale rvalid ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I IF stage, one outstanding fetch, 1-entry stall hold buffer, EX redirect/flush.
// Define IF_PERF_CNT_EN to add if_fetch_cnt/if_bubble_cnt performance counter outputs.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_IR,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_fetch_cnt,
    output logic [31:0] if_bubble_cnt
`endif
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HELD = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc_r, pc_inc, buf_ir, buf_pc;
    logic        resp, load_wait, load_held, load_new;

    assign pc_inc    = pc_r + 32'd4;
    assign resp      = state == S_WAIT && imem_rvalid;
    assign load_wait = resp && !stall && !redirect;
    assign load_held = state == S_HELD && !stall && !redirect;
    assign load_new  = load_wait || load_held;
    // In S_WAIT a consumed response immediately launches the next sequential fetch.
    assign imem_req  = !rst && ((state == S_REQ && !redirect) || load_wait);
    assign imem_addr = state == S_WAIT ? pc_inc : pc_r;

    always_comb begin
        state_nxt = state;
        if (redirect)
            state_nxt = ((state == S_WAIT || state == S_DROP) && !imem_rvalid) ? S_DROP : S_REQ;
        else
            case (state)
                S_REQ:   state_nxt = S_WAIT;
                S_WAIT:  state_nxt = (imem_rvalid && stall) ? S_HELD : S_WAIT;
                S_DROP:  state_nxt = imem_rvalid ? S_REQ : S_DROP;
                default: state_nxt = stall ? S_HELD : S_REQ;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_REQ;
            pc_r   <= RESET_PC & ~32'd3;
            buf_ir <= 32'd0;
            buf_pc <= 32'd0;
        end else begin
            state <= state_nxt;
            if (redirect)
                pc_r <= redirect_pc & ~32'd3;
            else if (resp)
                pc_r <= pc_inc;
            if (redirect || load_held) begin
                buf_ir <= 32'd0;
                buf_pc <= 32'd0;
            end else if (resp && stall) begin
                buf_ir <= imem_rdata;
                buf_pc <= pc_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_IR    <= NOP_INSTR;
            IF_ID_PC    <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (redirect) begin
            IF_ID_IR    <= NOP_INSTR;
            IF_ID_PC    <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (!stall) begin
            IF_ID_IR    <= load_wait ? imem_rdata : load_held ? buf_ir : NOP_INSTR;
            IF_ID_PC    <= load_wait ? pc_r : load_held ? buf_pc : IF_ID_PC;
            IF_ID_valid <= load_new;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_fetch_cnt  <= 32'd0;
            if_bubble_cnt <= 32'd0;
        end else begin
            if_fetch_cnt  <= if_fetch_cnt + {31'd0, load_new};
            if_bubble_cnt <= if_bubble_cnt + {31'd0, !stall && !load_new};
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed + random stimulus checked against a transaction-level fetch model.
module tb_instruction_fetch;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] MAGIC = 32'h5A5A_5A5A;

    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] redirect_pc = 32'd0, imem_rdata = 32'd0;
    logic        imem_req, if_v, req2, v2;
    logic [31:0] imem_addr, if_ir, if_pc, addr2, ir2, pc2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fcnt, bcnt, fcnt2, bcnt2;
`endif

    int errors = 0, checks = 0;

    // model: outstanding/discard flags, hold queue, expected IF/ID and counters
    logic        m_out, m_disc, e_v;
    logic [31:0] m_pc, e_ir, e_pc, e_fetch, e_bub;
    logic [63:0] m_hq[$];
    bit          mem_busy, chk2;
    int          mem_rem, lat;
    logic [31:0] mem_addr, exp2;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_IR(if_ir), .IF_ID_PC(if_pc), .IF_ID_valid(if_v)
`ifdef IF_PERF_CNT_EN
        , .if_fetch_cnt(fcnt), .if_bubble_cnt(bcnt)
`endif
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req2), .imem_addr(addr2), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_IR(ir2), .IF_ID_PC(pc2), .IF_ID_valid(v2)
`ifdef IF_PERF_CNT_EN
        , .if_fetch_cnt(fcnt2), .if_bubble_cnt(bcnt2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid();
        chk("if_id_ir", if_ir, e_ir);
        chk("if_id_pc", if_pc, e_pc);
        chk("if_id_valid", 32'(if_v), 32'(e_v));
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fcnt, e_fetch);
        chk("bubble_cnt", bcnt, e_bub);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        m_out = 1'b0; m_disc = 1'b0; m_pc = 32'd0; m_hq.delete();
        e_ir = NOP; e_pc = 32'd0; e_v = 1'b0; e_fetch = 32'd0; e_bub = 32'd0;
        mem_busy = 1'b0;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk_ifid();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit junk);
        logic idle, resp, ereq, ld, req_seen;
        logic [31:0] eaddr, addr_seen, rd;
        logic [63:0] e;
        stall = s;
        redirect = r;
        redirect_pc = rpc;
        if (mem_busy) mem_rem--;
        imem_rvalid = (mem_busy && mem_rem == 0) || (junk && !mem_busy);
        imem_rdata = mem_busy ? (mem_addr ^ MAGIC) : $urandom;
        #1;
        idle = !m_out && m_hq.size() == 0;
        resp = m_out && imem_rvalid;
        ereq = idle ? !r : (!m_disc && resp && !s && !r);
        eaddr = idle ? m_pc : m_pc + 32'd4;
        chk("imem_req", 32'(imem_req), 32'(ereq));
        if (ereq) chk("imem_addr", imem_addr, eaddr);
        if (chk2) begin
            chk("req2", 32'(req2), 32'd1);
            chk("addr2", addr2, exp2);
        end
        req_seen = imem_req;
        addr_seen = imem_addr;
        rd = imem_rdata;
        @(posedge clk);
        #1;
        if (mem_busy && mem_rem == 0) mem_busy = 1'b0;
        if (req_seen) begin
            mem_busy = 1'b1;
            mem_rem = lat != 0 ? lat : int'($urandom_range(1, 3));
            mem_addr = addr_seen;
        end
        ld = 1'b0;
        e = 64'd0;
        if (r) begin
            if (resp) begin
                m_out = 1'b0;
                m_disc = 1'b0;
            end else if (m_out) m_disc = 1'b1;
            m_hq.delete();
            m_pc = rpc & ~32'd3;
            e_ir = NOP; e_pc = 32'd0; e_v = 1'b0;
            if (!s) e_bub++;
        end else begin
            if (resp) begin
                if (m_disc) begin
                    m_out = 1'b0;
                    m_disc = 1'b0;
                end else if (s) begin
                    m_hq.push_back({rd, m_pc});
                    m_pc += 32'd4;
                    m_out = 1'b0;
                end else begin
                    e = {rd, m_pc};
                    ld = 1'b1;
                    m_pc += 32'd4;
                end
            end else if (idle) m_out = 1'b1;
            else if (m_hq.size() > 0 && !s) begin
                e = m_hq.pop_front();
                ld = 1'b1;
            end
            if (!s) begin
                if (ld) begin
                    {e_ir, e_pc} = e;
                    e_v = 1'b1;
                    e_fetch++;
                end else begin
                    e_ir = NOP;
                    e_v = 1'b0;
                    e_bub++;
                end
            end
        end
        chk_ifid();
    endtask

    initial begin
        chk2 = 1'b0;
        exp2 = 32'd0;
        lat = 1;
        #2;
        do_reset();
        // single-cycle memory streaming
        repeat (8) step(0, 0, 32'd0, 0);
        // latency 3
        lat = 3;
        repeat (10) step(0, 0, 32'd0, 0);
        // stall spanning a response
        lat = 2;
        step(0, 0, 32'd0, 0);
        repeat (4) step(1, 0, 32'd0, 0);
        repeat (5) step(0, 0, 32'd0, 0);
        // redirect with a fetch outstanding
        step(0, 1, 32'h0000_0100, 0);
        repeat (5) step(0, 0, 32'd0, 0);
        // redirect and stall together, misaligned target
        step(1, 1, 32'h0000_0103, 0);
        repeat (4) step(0, 0, 32'd0, 0);
        // wrap through the top of the address space
        step(0, 1, 32'hFFFF_FFF8, 0);
        lat = 1;
        repeat (5) step(0, 0, 32'd0, 0);
        // RESET_PC at the top: second fetch wraps to 0; stale rvalid right after reset
        do_reset();
        chk2 = 1'b1;
        exp2 = 32'hFFFF_FFFC;
        step(0, 0, 32'd0, 1);
        exp2 = 32'd0;
        step(0, 0, 32'd0, 0);
        chk2 = 1'b0;
        chk("pc2", pc2, 32'hFFFF_FFFC);
        chk("valid2", 32'(v2), 32'd1);
        // reset while a fetch is pending
        lat = 3;
        repeat (2) step(0, 0, 32'd0, 0);
        do_reset();
        step(0, 0, 32'd0, 1);
        repeat (4) step(0, 0, 32'd0, 0);
        // random traffic
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
